// File: rtl/mdu_iter_pkg.sv
// Shared MDU op codes, FSM state encoding and default latencies for the multiply/divide unit.
// MDU_MADD_EN selects whether op 7 is a multiply-accumulate or a NOP.
package mdu_iter_pkg;

    localparam int MDU_XLEN    = 32;
    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;

    typedef enum logic [2:0] {
        MDU_NOP   = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6,
        MDU_MADD  = 3'd7
    } mdu_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } mdu_state_e;

    function automatic logic mdu_is_div(input mdu_op_e op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    // Ops that occupy the unit for a multi-cycle RUN phase.
    function automatic logic mdu_is_run(input mdu_op_e op);
        logic w_run;
        w_run = (op == MDU_MULT) || (op == MDU_MULTU) || mdu_is_div(op);
`ifdef MDU_MADD_EN
        w_run = w_run || (op == MDU_MADD);
`endif
        return w_run;
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Restoring divider, ceil(32/DIV_LAT) quotient bits per cycle, first chunk on the load edge.
// Finishes within DIV_LAT edges of i_start; operands on i_a/i_b are only sampled at i_start.
module mdu_div_core
    import mdu_iter_pkg::*;
#(
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_signed,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_quo,
    output logic [31:0] o_rem,
    output logic        o_done
);

    localparam int         STEP   = (DIV_LAT >= 32) ? 1 : (32 + DIV_LAT - 1) / DIV_LAT;
    localparam logic [5:0] STEP_C = 6'(STEP);

    logic [31:0] r_rem;
    logic [31:0] r_dq;
    logic [31:0] r_dvs;
    logic [5:0]  r_left;
    logic        r_neg_q;
    logic        r_neg_r;

    logic [31:0] w_a_abs;
    logic [31:0] w_b_abs;
    logic [31:0] w_rem_in;
    logic [31:0] w_dq_in;
    logic [31:0] w_dvs_in;
    logic [5:0]  w_nbits;
    logic [63:0] w_step;

    // r_dq starts as the dividend and shifts quotient bits in from the right.
    function automatic logic [63:0] div_step(input logic [31:0] rem, input logic [31:0] dq,
                                             input logic [31:0] dvs, input logic [5:0] nbits);
        logic [32:0] t;
        logic [31:0] r;
        logic [31:0] q;
        r = rem;
        q = dq;
        for (int k = 0; k < STEP; k++) begin
            if (6'(k) < nbits) begin
                t = {r, q[31]};
                q = {q[30:0], 1'b0};
                if (t >= {1'b0, dvs}) begin
                    t    = t - {1'b0, dvs};
                    q[0] = 1'b1;
                end
                r = t[31:0];
            end
        end
        return {r, q};
    endfunction

    assign w_a_abs  = (i_signed && i_a[31]) ? (32'd0 - i_a) : i_a;
    assign w_b_abs  = (i_signed && i_b[31]) ? (32'd0 - i_b) : i_b;
    assign w_rem_in = i_start ? 32'd0   : r_rem;
    assign w_dq_in  = i_start ? w_a_abs : r_dq;
    assign w_dvs_in = i_start ? w_b_abs : r_dvs;
    assign w_nbits  = i_start ? STEP_C : ((r_left < STEP_C) ? r_left : STEP_C);
    assign w_step   = div_step(w_rem_in, w_dq_in, w_dvs_in, w_nbits);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rem   <= '0;
            r_dq    <= '0;
            r_dvs   <= '0;
            r_left  <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (i_start) begin
            r_rem   <= w_step[63:32];
            r_dq    <= w_step[31:0];
            r_dvs   <= w_b_abs;
            r_left  <= 6'd32 - STEP_C;
            r_neg_q <= i_signed && (i_a[31] ^ i_b[31]);
            r_neg_r <= i_signed && i_a[31];
        end else if (r_left != 6'd0) begin
            r_rem  <= w_step[63:32];
            r_dq   <= w_step[31:0];
            r_left <= r_left - w_nbits;
        end
    end

    // 0x80000000 / -1 falls out naturally: |q| = 2^31 negates back to 0x80000000.
    assign o_quo  = r_neg_q ? (32'd0 - r_dq)  : r_dq;
    assign o_rem  = r_neg_r ? (32'd0 - r_rem) : r_rem;
    assign o_done = (r_left == 6'd0);

endmodule

// File: rtl/mdu_iter.sv
// Multi-cycle MIPS multiply/divide unit writing HI/LO; busy held for MUL_LAT/DIV_LAT cycles.
// Optional MDU_MADD_EN turns op 7 into a signed multiply-accumulate; starts while busy are dropped.
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_busy,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    localparam int             MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int             CW      = $clog2(MAX_LAT + 1);
    localparam logic [CW-1:0]  MUL_CNT = CW'(MUL_LAT);
    localparam logic [CW-1:0]  DIV_CNT = CW'(DIV_LAT);

    mdu_state_e    r_state;
    logic [CW-1:0] r_cnt;
    mdu_op_e       r_op;
    logic [31:0]   r_a;
    logic [31:0]   r_b;
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;

    mdu_state_e    w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [31:0]   w_hi_nxt;
    logic [31:0]   w_lo_nxt;
    logic          w_cap;
    mdu_op_e       w_op;
    logic          w_sgn;
    logic [63:0]   w_a_ext;
    logic [63:0]   w_b_ext;
    logic [63:0]   w_prod;
    logic [31:0]   w_quo;
    logic [31:0]   w_rem;
    logic          w_div_done;

    assign w_op = mdu_op_e'(i_op);

`ifdef MDU_MADD_EN
    assign w_sgn = (r_op == MDU_MULT) || (r_op == MDU_MADD);
`else
    assign w_sgn = (r_op == MDU_MULT);
`endif

    // Sign/zero extension to 64 bits lets one unsigned multiplier serve MULT and MULTU.
    assign w_a_ext = {{32{w_sgn & r_a[31]}}, r_a};
    assign w_b_ext = {{32{w_sgn & r_b[31]}}, r_b};
    assign w_prod  = w_a_ext * w_b_ext;

    mdu_div_core #(
        .DIV_LAT (DIV_LAT)
    ) u_div (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_start  (w_cap && mdu_is_div(w_op)),
        .i_signed (w_op == MDU_DIV),
        .i_a      (i_a),
        .i_b      (i_b),
        .o_quo    (w_quo),
        .o_rem    (w_rem),
        .o_done   (w_div_done)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        w_cap       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (mdu_is_run(w_op)) begin
                        w_state_nxt = S_RUN;
                        w_cnt_nxt   = mdu_is_div(w_op) ? DIV_CNT : MUL_CNT;
                        w_cap       = 1'b1;
                    end else if (w_op == MDU_MTHI) begin
                        w_hi_nxt = i_a;
                    end else if (w_op == MDU_MTLO) begin
                        w_lo_nxt = i_a;
                    end
                end
            end
            S_RUN: begin
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = S_IDLE;
                    case (r_op)
                        MDU_MULT, MDU_MULTU: begin
                            w_hi_nxt = w_prod[63:32];
                            w_lo_nxt = w_prod[31:0];
                        end
                        MDU_DIV, MDU_DIVU: begin
                            // Divide by zero burns the full latency but leaves HI/LO alone.
                            if (w_div_done && (r_b != 32'd0)) begin
                                w_hi_nxt = w_rem;
                                w_lo_nxt = w_quo;
                            end
                        end
`ifdef MDU_MADD_EN
                        MDU_MADD: begin
                            {w_hi_nxt, w_lo_nxt} = {r_hi, r_lo} + w_prod;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= MDU_NOP;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            if (w_cap) begin
                r_op <= w_op;
                r_a  <= i_a;
                r_b  <= i_b;
            end
        end
    end

    assign o_busy = (r_state == S_RUN);
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: stimulus pushes expected HI/LO and latency, a monitor checks each busy fall.
// Reference model uses plain 64-bit arithmetic; honours MDU_MADD_EN like the DUT.
module tb_mdu_iter;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        string       nm;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    int          n_chk;
    int          n_err;

    mdu_iter #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_start (start),
        .i_op    (op),
        .i_a     (a),
        .i_b     (b),
        .o_busy  (busy),
        .o_hi    (hi),
        .o_lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic string op_name(input logic [2:0] o);
        case (o)
            3'd1: return "MULT";
            3'd2: return "MULTU";
            3'd3: return "DIV";
            3'd4: return "DIVU";
            3'd5: return "MTHI";
            3'd6: return "MTLO";
            3'd7: return "MADD";
            default: return "NOP";
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] o);
        case (o)
            3'd1, 3'd2: return MUL_LAT;
            3'd3, 3'd4: return DIV_LAT;
`ifdef MDU_MADD_EN
            3'd7: return MUL_LAT;
`endif
            default: return 0;
        endcase
    endfunction

    // Architectural effect of one accepted op on the model HI/LO.
    task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx;
        longint      sy;
        longint      r64;
        logic [63:0] acc;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            3'd1: begin
                r64 = sx * sy;
                {m_hi, m_lo} = r64;
            end
            3'd2: {m_hi, m_lo} = {32'd0, x} * {32'd0, y};
            3'd3: if (y != 0) begin
                r64  = sx / sy;
                m_lo = r64[31:0];
                r64  = sx % sy;
                m_hi = r64[31:0];
            end
            3'd4: if (y != 0) begin
                m_lo = x / y;
                m_hi = x % y;
            end
            3'd5: m_hi = x;
            3'd6: m_lo = x;
`ifdef MDU_MADD_EN
            3'd7: begin
                acc = {m_hi, m_lo};
                r64 = sx * sy;
                acc = acc + r64;
                {m_hi, m_lo} = acc;
            end
`endif
            default: ;
        endcase
    endtask

    // Monitor: counts busy cycles and checks HI/LO on every falling busy.
    initial begin
        int   cnt;
        logic prev;
        exp_t e;
        cnt  = 0;
        prev = 1'b0;
        forever begin
            @(negedge clk or posedge rst);
            if (rst) begin
                cnt  = 0;
                prev = 1'b0;
            end else begin
                if (busy) begin
                    cnt++;
                end else begin
                    if (prev) begin
                        if (q.size() == 0) begin
                            n_chk++;
                            n_err++;
                            $display("FAIL unexpected_commit: got hi=%0h lo=%0h expected no commit", hi, lo);
                        end else begin
                            e = q.pop_front();
                            chk({e.nm, "_lat"}, 64'(cnt), 64'(e.lat));
                            chk({e.nm, "_hi"}, 64'(hi), 64'(e.hi));
                            chk({e.nm, "_lo"}, 64'(lo), 64'(e.lo));
                        end
                    end
                    cnt = 0;
                end
                prev = busy;
            end
        end
    end

    // inj: percent chance per busy cycle of a (must-be-ignored) start; 100 alternates MULTU/MTLO.
    task automatic wait_done(input int inj);
        for (int i = 0; i < 64 && busy; i++) begin
            if ($urandom_range(0, 99) < inj) begin
                start = 1'b1;
                op    = (inj == 100) ? ((i % 2 == 0) ? 3'd2 : 3'd6) : 3'($urandom_range(0, 7));
                a     = $urandom;
                b     = $urandom;
            end
            @(negedge clk);
            start = 1'b0;
        end
        chk("busy_timeout", 64'(busy), 64'(0));
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input int inj);
        exp_t e;
        int   lat;
        @(negedge clk);
        lat = lat_of(o);
        model(o, x, y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (lat > 0) begin
            e.hi  = m_hi;
            e.lo  = m_lo;
            e.lat = lat;
            e.nm  = op_name(o);
            q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        op    = 3'($urandom_range(0, 7));
        a     = $urandom;
        b     = $urandom;
        if (lat == 0) begin
            chk({op_name(o), "_busy"}, 64'(busy), 64'(0));
            chk({op_name(o), "_hi"}, 64'(hi), 64'(m_hi));
            chk({op_name(o), "_lo"}, 64'(lo), 64'(m_lo));
        end else begin
            wait_done(inj);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        n_chk = 0;
        n_err = 0;
        m_hi  = '0;
        m_lo  = '0;
        rst   = 1'b1;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_hi", 64'(hi), 64'(0));
        chk("reset_lo", 64'(lo), 64'(0));
        rst = 1'b0;

        issue(3'd1, 32'hFFFF_FFFE, 32'd3, 0);
        issue(3'd2, 32'hFFFF_FFFE, 32'd3, 0);
        issue(3'd3, 32'hFFFF_FFF9, 32'd2, 0);
        issue(3'd4, 32'd7, 32'd2, 0);
        issue(3'd5, 32'h1234_5678, 32'd0, 0);
        issue(3'd6, 32'h9ABC_DEF0, 32'd0, 0);
        issue(3'd3, 32'd100, 32'd0, 0);
        issue(3'd1, 32'h0001_0003, 32'hFFFF_0005, 100);

        // Async reset on the third busy cycle of a divide.
        @(negedge clk);
        start = 1'b1;
        op    = 3'd3;
        a     = 32'd1000;
        b     = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_hi", 64'(hi), 64'(0));
        chk("arst_lo", 64'(lo), 64'(0));
        m_hi = '0;
        m_lo = '0;
        #2 rst = 1'b0;
        repeat (15) @(negedge clk);
        chk("post_arst_busy", 64'(busy), 64'(0));
        chk("post_arst_hilo", {hi, lo}, 64'(0));

        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        issue(3'd5, 32'h0000_0000, 32'd0, 0);
        issue(3'd6, 32'hFFFF_FFFF, 32'd0, 0);
        issue(3'd7, 32'd1, 32'd1, 0);
        issue(3'd0, 32'hDEAD_BEEF, 32'd1, 0);

        for (int n = 0; n < 60; n++) begin
            issue(3'($urandom_range(0, 7)), pick(), pick(), 30);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
